corner_apb_mem_init: RTL and testbench
======================================

Name: corner_apb_mem_init

Overview:
- APB3 completer that acts as the initiator of the register-file `mem_*` bus.
- Converts each APB transfer into exactly one single-beat `mem_*` access (`mem_ena`/`addr`/`wena`/`wdata` out, `rdata`/`err` in) and returns the result as `pready`/`prdata`/`pslverr`.
- Sits between the SoC APB fabric and a generated `*_regf` instance; the regf mem port is driven directly by this block.

Parameters:
- ADDR_W, 13, word-address width of `mem_addr_o`; `apb_paddr_i` is ADDR_W+2 bits (byte address).
- DATA_W, 32, data width of both the APB and mem buses.
- RESP_LAT, 1, cycles from `mem_ena_o` high to `mem_rdata_i`/`mem_err_i` valid; legal range 1..4.
- ADDR_LIMIT, 2**ADDR_W, number of implemented words; used only with the optional feature.

Ports:
- main_clk_i  in  1  clock.
- main_rst_an_i  in  1  synchronous reset, active-low.
- apb_psel_i  in  1  APB select.
- apb_penable_i  in  1  APB access phase.
- apb_pwrite_i  in  1  1 = write.
- apb_paddr_i  in  ADDR_W+2  byte address.
- apb_pwdata_i  in  DATA_W  write data.
- apb_pready_o  out  1  transfer complete.
- apb_prdata_o  out  DATA_W  read data, valid with pready on reads.
- apb_pslverr_o  out  1  error, valid with pready.
- mem_ena_o  out  1  mem access strobe, one cycle per access.
- mem_addr_o  out  ADDR_W  word address, = paddr[ADDR_W+1:2].
- mem_wena_o  out  1  1 = write.
- mem_wdata_o  out  DATA_W  write data.
- mem_rdata_i  in  DATA_W  read data, valid RESP_LAT cycles after ena.
- mem_err_i  in  1  access error, valid RESP_LAT cycles after ena.

Behaviour:
- Outputs are registered. Reset (`main_rst_an_i`=0 at a rising edge) forces all outputs to 0 and the FSM to IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `psel`=1 and `penable`=0 (setup phase) → capture `pwrite`, `paddr`, `pwdata`.
  - If `paddr[1:0]`≠0 (misaligned): go to RESP with err=1; no mem access.
  - Otherwise go to ISSUE.
- ISSUE (one cycle):
  - `mem_ena_o`=1; `mem_addr_o`, `mem_wena_o`, `mem_wdata_o` hold the captured values.
  - Load a 2-bit latency counter with RESP_LAT-1, then go to WAIT.
  - In all other states `mem_ena_o`=0 and `mem_wena_o`=0. `mem_addr_o`/`mem_wdata_o` hold their last value.
- WAIT:
  - Counter≠0 → decrement.
  - Counter=0 → the mem response is valid this cycle. Capture `mem_rdata_i` (reads only; writes capture 0) and `mem_err_i`, then go to RESP.
- RESP (exactly one cycle):
  - `apb_pready_o`=1, `apb_prdata_o`=captured data, `apb_pslverr_o`=captured err.
  - Always go to IDLE; `pready`/`prdata`/`pslverr` return to 0 the next cycle.
  - `prdata` is 0 on writes and on errors.
- Latency: setup in cycle T0 → `mem_ena_o` in T1 → `pready` in T1+RESP_LAT+1. With RESP_LAT=1, `pready` is in T3.
- Back-to-back transfers: a setup phase in the cycle after RESP is accepted. Minimum spacing is RESP_LAT+3 cycles per transfer.
- `psel`/`penable` are ignored outside IDLE; no second capture while busy.
- `psel` dropped mid-transfer (protocol violation): the issued mem access completes. RESP still pulses for one cycle, then IDLE. No hang and no double access.
- `penable`=1 seen in IDLE without a preceding setup: ignored.
- Reset mid-operation: FSM → IDLE at the reset edge. The in-flight mem response is discarded; no `pready` is generated.
- `mem_err_i`=1 on a read: `pslverr`=1 and `prdata`=0.

Optional Feature:
- Macro: CORNER_APB_MEM_INIT_RANGE_CHECK_EN.
- Defined:
  - An aligned address with word index ≥ ADDR_LIMIT goes IDLE→RESP with `pslverr`=1, `prdata`=0. No mem access (`mem_ena_o` stays 0).
  - Latency for rejected transfers is setup+1.
- Undefined: ADDR_LIMIT is unused and all aligned addresses are forwarded; the mem side reports errors via `mem_err_i`.

Test Plan:
- Write paddr=0x0010, pwdata=0xDEADBEEF, RESP_LAT=1 → `mem_ena_o` 1 cycle after setup with `mem_addr_o`=0x0004, `wena`=1, `wdata`=0xDEADBEEF; `pready`=1 in T3, `pslverr`=0, `prdata`=0.
- Read paddr=0x0004, mem returns 0x12345678 one cycle after ena → `pready` in T3 with `prdata`=0x12345678, `pslverr`=0; exactly one `mem_ena_o` pulse.
- Read paddr=0x0002 (misaligned) → no `mem_ena_o`; `pready`=1 and `pslverr`=1 in T1; `prdata`=0.
- Read with `mem_err_i`=1 and `mem_rdata_i`=0xFFFFFFFF, RESP_LAT=3 → `pready` in T5, `pslverr`=1, `prdata`=0.
- Two back-to-back writes (addresses 0x0, 0x4), second setup in the cycle after the first `pready` → two `mem_ena_o` pulses 4 cycles apart, both `pready` without error; then assert reset in the WAIT of a third read → no `pready`, all outputs 0 next cycle, IDLE accepts a new setup after reset release.
- With CORNER_APB_MEM_INIT_RANGE_CHECK_EN and ADDR_LIMIT=16: read paddr=0x0040 → no `mem_ena_o`, `pslverr`=1 in T1. Read paddr=0x003C → forwarded normally.

Source files
------------

// File: rtl/corner_apb_mem_init_if.sv
// APB3 completer signals plus the regf mem port, bundled for the bridge and its environment.
// slave is the bridge view; master is the fabric/regf view.
interface corner_apb_mem_init_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32
);
   logic              apb_psel_i;
   logic              apb_penable_i;
   logic              apb_pwrite_i;
   logic [ADDR_W+1:0] apb_paddr_i;
   logic [DATA_W-1:0] apb_pwdata_i;
   logic              apb_pready_o;
   logic [DATA_W-1:0] apb_prdata_o;
   logic              apb_pslverr_o;
   logic              mem_ena_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_wena_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;
   logic              mem_err_i;

   modport slave (
      input  apb_psel_i, apb_penable_i, apb_pwrite_i, apb_paddr_i, apb_pwdata_i,
      input  mem_rdata_i, mem_err_i,
      output apb_pready_o, apb_prdata_o, apb_pslverr_o,
      output mem_ena_o, mem_addr_o, mem_wena_o, mem_wdata_o
   );

   modport master (
      output apb_psel_i, apb_penable_i, apb_pwrite_i, apb_paddr_i, apb_pwdata_i,
      output mem_rdata_i, mem_err_i,
      input  apb_pready_o, apb_prdata_o, apb_pslverr_o,
      input  mem_ena_o, mem_addr_o, mem_wena_o, mem_wdata_o
   );
endinterface

// File: rtl/corner_apb_mem_init.sv
// APB3 completer driving a single-beat regf mem bus; CORNER_APB_MEM_INIT_RANGE_CHECK_EN rejects words >= ADDR_LIMIT.
// Setup->pready is RESP_LAT+2 cycles (rejects: 1); one transfer in flight, APB stalled until pready, mem side never stalls.
module corner_apb_mem_init #(
   parameter int ADDR_W     = 13,
   parameter int DATA_W     = 32,
   parameter int RESP_LAT   = 1,
   parameter int ADDR_LIMIT = 2**ADDR_W
) (
   input  logic                  main_clk_i,
   input  logic                  main_rst_an_i,
   corner_apb_mem_init_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [1:0] CNT_INIT = 2'(RESP_LAT - 1);

   if (RESP_LAT < 1 || RESP_LAT > 4 || ADDR_LIMIT < 1 || ADDR_LIMIT > 2**ADDR_W) begin : g_param_err
      $error("corner_apb_mem_init: RESP_LAT or ADDR_LIMIT out of range");
   end

   state_t              state_q, state_d;
   logic                cap_write_q, cap_write_d;
   logic [1:0]          cnt_q, cnt_d;
   logic                mem_ena_q, mem_ena_d;
   logic                mem_wena_q, mem_wena_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                pready_q, pready_d;
   logic [DATA_W-1:0]   prdata_q, prdata_d;
   logic                pslverr_q, pslverr_d;

   logic                setup;
   logic                misaligned;
   logic                reject;
   logic [ADDR_W-1:0]   word_idx;

   assign setup      = bus.apb_psel_i && !bus.apb_penable_i;
   assign word_idx   = bus.apb_paddr_i[ADDR_W+1:2];
   assign misaligned = |bus.apb_paddr_i[1:0];

`ifdef CORNER_APB_MEM_INIT_RANGE_CHECK_EN
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(ADDR_LIMIT);
   assign reject = misaligned || ({1'b0, word_idx} >= LIMIT);
`else
   assign reject = misaligned;
`endif

   always_comb begin
      state_d     = state_q;
      cap_write_d = cap_write_q;
      cnt_d       = cnt_q;
      mem_ena_d   = 1'b0;
      mem_wena_d  = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      pready_d    = 1'b0;
      prdata_d    = '0;
      pslverr_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (setup) begin
               cap_write_d = bus.apb_pwrite_i;
               if (reject) begin
                  // Rejected transfers answer straight away without touching the regf.
                  state_d   = RESP;
                  pready_d  = 1'b1;
                  pslverr_d = 1'b1;
               end else begin
                  state_d     = ISSUE;
                  mem_ena_d   = 1'b1;
                  mem_wena_d  = bus.apb_pwrite_i;
                  mem_addr_d  = word_idx;
                  mem_wdata_d = bus.apb_pwdata_i;
               end
            end
         end
         ISSUE: begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q != 2'd0) begin
               cnt_d = cnt_q - 2'd1;
            end else begin
               state_d   = RESP;
               pready_d  = 1'b1;
               pslverr_d = bus.mem_err_i;
               prdata_d  = (cap_write_q || bus.mem_err_i) ? '0 : bus.mem_rdata_i;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge main_clk_i) begin
      if (!main_rst_an_i) begin
         state_q     <= IDLE;
         cap_write_q <= 1'b0;
         cnt_q       <= 2'd0;
         mem_ena_q   <= 1'b0;
         mem_wena_q  <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         pready_q    <= 1'b0;
         prdata_q    <= '0;
         pslverr_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cap_write_q <= cap_write_d;
         cnt_q       <= cnt_d;
         mem_ena_q   <= mem_ena_d;
         mem_wena_q  <= mem_wena_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         pready_q    <= pready_d;
         prdata_q    <= prdata_d;
         pslverr_q   <= pslverr_d;
      end
   end

   assign bus.mem_ena_o     = mem_ena_q;
   assign bus.mem_wena_o    = mem_wena_q;
   assign bus.mem_addr_o    = mem_addr_q;
   assign bus.mem_wdata_o   = mem_wdata_q;
   assign bus.apb_pready_o  = pready_q;
   assign bus.apb_prdata_o  = prdata_q;
   assign bus.apb_pslverr_o = pslverr_q;
endmodule

// File: tb/tb_corner_apb_mem_init.sv
// Bench for corner_apb_mem_init: RESP_LAT=1 instance for most scenarios, RESP_LAT=3 instance for the slow-error case.
module tb_corner_apb_mem_init;
   localparam int ADDR_W = 13;
   localparam int DATA_W = 32;
   localparam int LIMIT  = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic plan_err = 1'b0;
   logic [31:0] rmem [64];
   logic [31:0] ref_mem [64];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   corner_apb_mem_init_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();
   corner_apb_mem_init_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus3 ();

   corner_apb_mem_init #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESP_LAT(1), .ADDR_LIMIT(LIMIT)) u_dut1 (
      .main_clk_i(clk), .main_rst_an_i(rst_n), .bus(bus1));
   corner_apb_mem_init #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESP_LAT(3), .ADDR_LIMIT(LIMIT)) u_dut3 (
      .main_clk_i(clk), .main_rst_an_i(rst_n), .bus(bus3));

   // Regf model for the RESP_LAT=1 instance; drives garbage outside the valid response cycle.
   initial begin
      int due;
      logic pend, e;
      logic [5:0] a;
      pend = 1'b0; due = 0; e = 1'b0; a = '0;
      bus1.mem_rdata_i = '0;
      bus1.mem_err_i   = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (pend && cyc == due) begin
            bus1.mem_rdata_i = rmem[a];
            bus1.mem_err_i   = e;
            pend = 1'b0;
         end else begin
            bus1.mem_rdata_i = $urandom;
            bus1.mem_err_i   = 1'($urandom);
         end
         if (bus1.mem_ena_o === 1'b1) begin
            a = bus1.mem_addr_o[5:0];
            e = plan_err;
            pend = 1'b1;
            due = cyc + 1;
            if (bus1.mem_wena_o && !plan_err) rmem[a] = bus1.mem_wdata_o;
         end
      end
   end

   // Regf model for the RESP_LAT=3 instance: always errors with all-ones data.
   initial begin
      int due;
      logic pend;
      pend = 1'b0; due = 0;
      bus3.mem_rdata_i = '0;
      bus3.mem_err_i   = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (pend && cyc == due) begin
            bus3.mem_rdata_i = 32'hFFFF_FFFF;
            bus3.mem_err_i   = 1'b1;
            pend = 1'b0;
         end else begin
            bus3.mem_rdata_i = $urandom;
            bus3.mem_err_i   = 1'b0;
         end
         if (bus3.mem_ena_o === 1'b1) begin
            pend = 1'b1;
            due = cyc + 3;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // One APB transfer on bus1, checked against the transaction-level model.
   task automatic xfer(input logic wr, input logic [14:0] paddr, input logic [31:0] wdata,
                       input logic err, input logic drop, input string tag, output int ena_abs);
      int t0, ena_cnt, ena_at, rdy_at, exp_rdy;
      logic fwd, exp_err, got_wena, got_err;
      logic [31:0] exp_data, got_wdata, got_prdata;
      logic [12:0] exp_addr, got_addr;
      fwd = (paddr[1:0] == 2'b00);
`ifdef CORNER_APB_MEM_INIT_RANGE_CHECK_EN
      if ((paddr >> 2) >= LIMIT) fwd = 1'b0;
`endif
      exp_addr = paddr[14:2];
      exp_err  = !fwd || err;
      exp_data = (wr || exp_err) ? 32'h0 : ref_mem[exp_addr[5:0]];
      if (fwd && wr && !err) ref_mem[exp_addr[5:0]] = wdata;
      exp_rdy  = fwd ? 3 : 1;
      plan_err = err;
      got_addr = '0; got_wena = 1'b0; got_wdata = '0; got_prdata = '0; got_err = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus1.apb_pready_o !== 1'b0) begin
         n_fail++; $display("FAIL %s pready_idle got %b want 0", tag, bus1.apb_pready_o);
      end
      bus1.apb_psel_i    = 1'b1;
      bus1.apb_penable_i = 1'b0;
      bus1.apb_pwrite_i  = wr;
      bus1.apb_paddr_i   = paddr;
      bus1.apb_pwdata_i  = wdata;
      t0 = cyc; ena_cnt = 0; ena_at = -1; rdy_at = -1;
      for (int i = 1; i <= 16 && rdy_at < 0; i++) begin
         @(negedge clk);
         if (i == 1) begin
            if (drop) begin
               bus1.apb_psel_i = 1'b0;
               bus1.apb_penable_i = 1'b0;
            end else begin
               bus1.apb_penable_i = 1'b1;
            end
         end
         if (bus1.mem_ena_o === 1'b1) begin
            ena_cnt++; ena_at = i;
            got_addr = bus1.mem_addr_o; got_wena = bus1.mem_wena_o; got_wdata = bus1.mem_wdata_o;
         end
         if (bus1.apb_pready_o === 1'b1) begin
            rdy_at = i; got_prdata = bus1.apb_prdata_o; got_err = bus1.apb_pslverr_o;
         end
      end
      ena_abs = t0 + ena_at;
      n_checks++;
      if (rdy_at != exp_rdy) begin
         n_fail++; $display("FAIL %s pready_cycle got %0d want %0d", tag, rdy_at, exp_rdy);
      end
      n_checks++;
      if (ena_cnt != (fwd ? 1 : 0)) begin
         n_fail++; $display("FAIL %s mem_ena_count got %0d want %0d", tag, ena_cnt, fwd ? 1 : 0);
      end
      n_checks++;
      if (got_err !== exp_err) begin
         n_fail++; $display("FAIL %s pslverr got %b want %b", tag, got_err, exp_err);
      end
      n_checks++;
      if (got_prdata !== exp_data) begin
         n_fail++; $display("FAIL %s prdata got %h want %h", tag, got_prdata, exp_data);
      end
      if (fwd) begin
         n_checks++;
         if (ena_at != 1 || got_addr !== exp_addr || got_wena !== wr) begin
            n_fail++;
            $display("FAIL %s mem_req at=%0d addr=%h wena=%b want at=1 addr=%h wena=%b",
                     tag, ena_at, got_addr, got_wena, exp_addr, wr);
         end
         if (wr) begin
            n_checks++;
            if (got_wdata !== wdata) begin
               n_fail++; $display("FAIL %s mem_wdata got %h want %h", tag, got_wdata, wdata);
            end
         end
      end
   endtask

   // Idle cycles with psel/penable noise that never forms a setup phase.
   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus1.mem_ena_o !== 1'b0 || bus1.apb_pready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_quiet ena=%b pready=%b want 0 0", tag, bus1.mem_ena_o, bus1.apb_pready_o);
         end
         case ($urandom % 3)
            0: begin bus1.apb_psel_i = 1'b0; bus1.apb_penable_i = 1'b0; end
            1: begin bus1.apb_psel_i = 1'b0; bus1.apb_penable_i = 1'b1; end
            default: begin bus1.apb_psel_i = 1'b1; bus1.apb_penable_i = 1'b1; end
         endcase
         bus1.apb_paddr_i = 15'($urandom);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus1.apb_psel_i = 1'b1; bus1.apb_penable_i = 1'b0; bus1.apb_pwrite_i = 1'b1;
      bus1.apb_paddr_i = 15'h0002; bus1.apb_pwdata_i = 32'hA5A5_A5A5;
      bus3.apb_psel_i = 1'b0; bus3.apb_penable_i = 1'b0; bus3.apb_pwrite_i = 1'b0;
      bus3.apb_paddr_i = '0; bus3.apb_pwdata_i = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus1.apb_pready_o, bus1.apb_pslverr_o, bus1.mem_ena_o, bus1.mem_wena_o} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctrl got pready=%b pslverr=%b ena=%b wena=%b want 0", bus1.apb_pready_o,
                  bus1.apb_pslverr_o, bus1.mem_ena_o, bus1.mem_wena_o);
      end
      n_checks++;
      if (bus1.apb_prdata_o !== 32'h0 || bus1.mem_wdata_o !== 32'h0 || bus1.mem_addr_o !== 13'h0) begin
         n_fail++;
         $display("FAIL reset_data got prdata=%h wdata=%h addr=%h want 0", bus1.apb_prdata_o,
                  bus1.mem_wdata_o, bus1.mem_addr_o);
      end
      n_checks++;
      if (bus3.apb_pready_o !== 1'b0 || bus3.mem_ena_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_lat3 got pready=%b ena=%b want 0 0", bus3.apb_pready_o, bus3.mem_ena_o);
      end
      bus1.apb_psel_i = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int e;
      xfer(1'b1, 15'h0010, 32'hDEAD_BEEF, 1'b0, 1'b0, "write_basic", e);
      rmem[1] = 32'h1234_5678; ref_mem[1] = 32'h1234_5678;
      xfer(1'b0, 15'h0004, 32'h0, 1'b0, 1'b0, "read_basic", e);
      xfer(1'b0, 15'h0002, 32'h0, 1'b0, 1'b0, "misaligned", e);
      xfer(1'b0, 15'h0010, 32'h0, 1'b0, 1'b0, "read_back", e);
      xfer(1'b0, 15'h0004, 32'h0, 1'b1, 1'b0, "read_mem_err", e);
      idle(2, "basic_gap");
   endtask

   task automatic test_err_lat3();
      int ena_at, rdy_at, ena_cnt;
      logic got_err;
      logic [31:0] got_prdata;
      @(negedge clk);
      bus3.apb_psel_i = 1'b1; bus3.apb_penable_i = 1'b0; bus3.apb_pwrite_i = 1'b0;
      bus3.apb_paddr_i = 15'h0008;
      ena_at = -1; rdy_at = -1; ena_cnt = 0; got_err = 1'b0; got_prdata = '0;
      for (int i = 1; i <= 16 && rdy_at < 0; i++) begin
         @(negedge clk);
         if (i == 1) bus3.apb_penable_i = 1'b1;
         if (bus3.mem_ena_o === 1'b1) begin ena_cnt++; ena_at = i; end
         if (bus3.apb_pready_o === 1'b1) begin
            rdy_at = i; got_err = bus3.apb_pslverr_o; got_prdata = bus3.apb_prdata_o;
         end
      end
      n_checks++;
      if (rdy_at != 5 || ena_at != 1 || ena_cnt != 1) begin
         n_fail++; $display("FAIL lat3_timing got rdy=%0d ena=%0d cnt=%0d want 5 1 1", rdy_at, ena_at, ena_cnt);
      end
      n_checks++;
      if (got_err !== 1'b1 || got_prdata !== 32'h0) begin
         n_fail++; $display("FAIL lat3_err got pslverr=%b prdata=%h want 1 0", got_err, got_prdata);
      end
      bus3.apb_psel_i = 1'b0; bus3.apb_penable_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus3.apb_pready_o !== 1'b0) begin
         n_fail++; $display("FAIL lat3_pready_pulse got %b want 0", bus3.apb_pready_o);
      end
   endtask

   task automatic test_back_to_back();
      int e0, e1;
      xfer(1'b1, 15'h0000, 32'h0000_1111, 1'b0, 1'b0, "b2b_first", e0);
      xfer(1'b1, 15'h0004, 32'h0000_2222, 1'b0, 1'b0, "b2b_second", e1);
      n_checks++;
      if (e1 - e0 != 4) begin
         n_fail++; $display("FAIL b2b_spacing got %0d want 4", e1 - e0);
      end
   endtask

   task automatic test_reset_mid();
      int e;
      plan_err = 1'b0;
      @(negedge clk);
      bus1.apb_psel_i = 1'b1; bus1.apb_penable_i = 1'b0; bus1.apb_pwrite_i = 1'b0;
      bus1.apb_paddr_i = 15'h0008;
      @(negedge clk);
      bus1.apb_penable_i = 1'b1;
      n_checks++;
      if (bus1.mem_ena_o !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid_issue mem_ena got %b want 1", bus1.mem_ena_o);
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bus1.apb_pready_o, bus1.apb_pslverr_o, bus1.mem_ena_o, bus1.mem_wena_o} !== 4'b0000 ||
          bus1.apb_prdata_o !== 32'h0 || bus1.mem_addr_o !== 13'h0 || bus1.mem_wdata_o !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs got pready=%b ena=%b addr=%h wdata=%h want all 0", bus1.apb_pready_o,
                  bus1.mem_ena_o, bus1.mem_addr_o, bus1.mem_wdata_o);
      end
      bus1.apb_psel_i = 1'b0; bus1.apb_penable_i = 1'b0;
      rst_n = 1'b1;
      idle(3, "rst_mid_after");
      xfer(1'b0, 15'h0000, 32'h0, 1'b0, 1'b0, "rst_mid_recover", e);
   endtask

   task automatic test_range();
      int e;
      xfer(1'b0, 15'h0040, 32'h0, 1'b0, 1'b0, "range_0x40", e);
      xfer(1'b0, 15'h003C, 32'h0, 1'b0, 1'b0, "range_0x3C", e);
      idle(1, "range_gap");
   endtask

   task automatic test_random();
      int e;
      logic wr, err, drop;
      logic [14:0] paddr;
      for (int n = 0; n < 80; n++) begin
         wr    = 1'($urandom);
         paddr = 15'(($urandom % 32) * 4);
         if ($urandom % 6 == 0) paddr[1:0] = 2'($urandom_range(1, 3));
         err   = ($urandom % 5 == 0);
         drop  = ($urandom % 8 == 0);
         xfer(wr, paddr, $urandom, err, drop, "random", e);
         if ($urandom % 2 == 1) idle($urandom_range(1, 3), "random_gap");
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         rmem[i] = $urandom;
         ref_mem[i] = rmem[i];
      end
      test_reset();
      test_basic();
      test_err_lat3();
      test_back_to_back();
      test_reset_mid();
      test_range();
      test_random();
      idle(2, "final");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
